serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder with carry-in. Built around a single 1-bit full-adder cell (sum = a^b^c, carry = majority(a,b,c)) plus a carry flip-flop, operand shift registers and a control FSM. It accepts operands over a valid/ready handshake, adds one bit per clock LSB-first, and presents the registered result on a second valid/ready handshake. It trades latency for area, so the team uses it where a ripple-carry chain of full adders is too large.

---
 rtl/serial_adder.sv | 129 ++++++++++++
 tb/tb_serial_adder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder
//
// Bit-serial WIDTH-bit unsigned adder with carry-in. One full-adder cell and
// a carry flip-flop process one bit per clock, LSB first, so an add takes
// WIDTH clocks instead of a WIDTH-cell ripple chain.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands a, b, c_in are presented
//   in_ready   block accepts operands (IDLE only)
//   a, b       WIDTH-bit unsigned operands
//   c_in       carry into bit 0
//   out_valid  sum / c_out hold a completed result (DONE only)
//   out_ready  consumer takes the result
//   sum        registered (a + b + c_in) mod 2^WIDTH
//   c_out      registered carry out of bit WIDTH-1
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int                CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum_sr;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic               w_fa_sum;
    logic               w_fa_carry;
    logic [WIDTH-1:0]   w_sum_shift;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_cnt == LAST);

    // Single full-adder cell working on the current LSBs
    assign w_fa_sum   = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_fa_carry = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) |
                        (r_b_sr[0] & r_carry);

    // Sum bit enters at the MSB so after WIDTH shifts bit 0 sits at index 0.
    // Written as shift-then-overwrite so WIDTH=1 needs no special slice.
    always_comb begin
        w_sum_shift            = r_sum_sr >> 1;
        w_sum_shift[WIDTH-1]   = w_fa_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Handshake flags come straight from the state register
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_carry  <= c_in;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_sum_sr <= w_sum_shift;
            r_carry  <= w_fa_carry;
            r_cnt    <= r_cnt + CNT_W'(1);
            // Result registers update only when the last bit is produced,
            // so they hold the previous result through IDLE and RUN.
            if (w_last) begin
                r_sum  <= w_sum_shift;
                r_cout <= w_fa_carry;
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       c_out;

    logic       w1_in_valid;
    logic       w1_in_ready;
    logic [0:0] w1_a;
    logic [0:0] w1_b;
    logic       w1_c_in;
    logic       w1_out_valid;
    logic       w1_out_ready;
    logic [0:0] w1_sum;
    logic       w1_c_out;

    int vectors;
    int miscompares;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w1_in_valid),
        .in_ready  (w1_in_ready),
        .a         (w1_a),
        .b         (w1_b),
        .c_in      (w1_c_in),
        .out_valid (w1_out_valid),
        .out_ready (w1_out_ready),
        .sum       (w1_sum),
        .c_out     (w1_c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain unsigned addition at WIDTH+1 bits
    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {8'd0, ci};
    endfunction

    // One full transaction on the 8-bit instance; returns result and the
    // number of negedges from the acceptance edge until out_valid.
    task automatic run_txn(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                           output logic [8:0] res, output int lat);
        @(negedge clk);
        a = xa; b = xb; c_in = xc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = {c_out, sum};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, c_out, sum} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b co=%b sum=%h required rdy=1 vld=0 co=0 sum=00",
                     in_ready, out_valid, c_out, sum);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic check_txn(input string name, input logic [7:0] xa, input logic [7:0] xb, input logic xc);
        logic [8:0] res;
        logic [8:0] exp;
        int         lat;
        exp = ref_add(xa, xb, xc);
        run_txn(xa, xb, xc, res, lat);
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d required 8", name, lat);
        end
        vectors++;
        if (res !== exp) begin
            miscompares++;
            $display("FAIL %s_result: a=%h b=%h ci=%b got %h required %h", name, xa, xb, xc, res, exp);
        end
    endtask

    task automatic test_basic;
        check_txn("basic", 8'h5A, 8'h3C, 1'b0);
    endtask

    task automatic test_carry;
        check_txn("carry_ff_01", 8'hFF, 8'h01, 1'b0);
        check_txn("carry_ff_ff_1", 8'hFF, 8'hFF, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            check_txn("random", 8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_mid_run_reset;
        @(negedge clk);
        a = 8'hC3; b = 8'h7E; c_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, c_out, sum} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL midrun_reset: got rdy=%b vld=%b co=%b sum=%h required rdy=1 vld=0 co=0 sum=00",
                     in_ready, out_valid, c_out, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_release: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
        end
        check_txn("after_reset", 8'h81, 8'h92, 1'b0);
    endtask

    task automatic test_backpressure;
        logic [8:0] exp1;
        logic [8:0] exp2;
        int         lat;
        exp1 = ref_add(8'h37, 8'hA9, 1'b1);
        exp2 = ref_add(8'hE4, 8'h2B, 1'b0);
        @(negedge clk);
        a = 8'h37; b = 8'hA9; c_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d required 8", lat);
        end
        a = 8'hE4; b = 8'h2B; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({c_out, sum} !== exp1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold: cycle %0d got res=%h rdy=%b vld=%b required res=%h rdy=0 vld=1",
                         i, {c_out, sum}, in_ready, out_valid, exp1);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat !== 8 || {c_out, sum} !== exp2) begin
            miscompares++;
            $display("FAIL bp_second: got lat=%0d res=%h required lat=8 res=%h", lat, {c_out, sum}, exp2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] pa[4];
        logic [7:0] pb[4];
        logic       pc[4];
        logic [8:0] exp;
        int         n_in;
        int         n_out;
        int         last_out;
        bit         pend;
        for (int i = 0; i < 4; i++) begin
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
            pc[i] = 1'($urandom);
        end
        n_in = 0;
        n_out = 0;
        last_out = -1;
        @(negedge clk);
        a = pa[0]; b = pb[0]; c_in = pc[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && n_out < 4; cyc++) begin
            pend = (in_ready === 1'b1) && (in_valid === 1'b1);
            if (out_valid === 1'b1) begin
                exp = ref_add(pa[n_out], pb[n_out], pc[n_out]);
                vectors++;
                if ({c_out, sum} !== exp) begin
                    miscompares++;
                    $display("FAIL b2b_result: #%0d got %h required %h", n_out, {c_out, sum}, exp);
                end
                if (last_out >= 0) begin
                    vectors++;
                    if (cyc - last_out != 10) begin
                        miscompares++;
                        $display("FAIL b2b_interval: #%0d got %0d required 10", n_out, cyc - last_out);
                    end
                end
                last_out = cyc;
                n_out++;
            end
            @(negedge clk);
            if (pend) begin
                n_in++;
                if (n_in < 4) begin
                    a = pa[n_in]; b = pb[n_in]; c_in = pc[n_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (n_out != 4) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results required 4", n_out);
        end
    endtask

    task automatic test_width1;
        logic [1:0] exp;
        int         lat;
        for (int i = 0; i < 8; i++) begin
            exp = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
            @(negedge clk);
            w1_a = i[2]; w1_b = i[1]; w1_c_in = i[0]; w1_in_valid = 1'b1;
            @(negedge clk);
            w1_in_valid = 1'b0;
            lat = 0;
            while (w1_out_valid !== 1'b1 && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            vectors++;
            if (lat !== 1 || {w1_c_out, w1_sum} !== exp) begin
                miscompares++;
                $display("FAIL w1_combo: a=%b b=%b ci=%b got lat=%0d res=%b required lat=1 res=%b",
                         i[2], i[1], i[0], lat, {w1_c_out, w1_sum}, exp);
            end
            w1_out_ready = 1'b1;
            @(negedge clk);
            w1_out_ready = 1'b0;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
        w1_in_valid = 1'b0; w1_a = '0; w1_b = '0; w1_c_in = 1'b0; w1_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_random();
        test_mid_run_reset();
        test_backpressure();
        test_back_to_back();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
